instr_pair_buffer: RTL and testbench
====================================

// Module: instr_pair_buffer
// PURPOSE
//   Decoupling queue between Instruction_Fetch and the dual-issue decode stage. Captures
//   aligned even/odd instruction pairs with their word-address program counter and
//   presents them to decode under a valid/ready handshake. A branch flush discards all
//   queued pairs in one cycle. This absorbs decode stalls without stalling fetch every cycle.
// PARAMETERS
//   DEPTH    4   queue capacity in instruction pairs; power of two, >= 2
//   INSTR_W  32  instruction width in bits
//   PC_W     8   program-counter width (word address into instruction memory)
// PORTS
//   clock             in   1                    rising-edge clock
//   reset             in   1                    synchronous, active-high reset
//   fetch_valid       in   1                    fetch presents a pair this cycle
//   fetch_pc          in   PC_W                 word address of first valid instruction
//   fetch_instr_even  in   INSTR_W              instruction at (fetch_pc & ~1)
//   fetch_instr_odd   in   INSTR_W              instruction at (fetch_pc | 1)
//   fetch_ready       out  1                    queue accepts a pair (not full)
//   flush             in   1                    branch taken: discard all entries
//   decode_ready      in   1                    decode consumes head pair this cycle
//   decode_valid      out  1                    head pair is valid
//   decode_pc         out  PC_W                 stored fetch_pc of head pair
//   decode_even_valid out  1                    even slot of head is issuable
//   decode_instr_even out  INSTR_W              head even instruction
//   decode_instr_odd  out  INSTR_W              head odd instruction
//   count             out  $clog2(DEPTH+1)      occupied entries
// BEHAVIOUR
//   - One clock; reset is synchronous and active-high. Reset: pointers=0, count=0,
//     fetch_ready=1, decode_valid=0, decode_even_valid=0, decode_pc=0, instr outputs=0.
//   - push = fetch_valid & fetch_ready; pop = decode_valid & decode_ready.
//   - fetch_ready = (count != DEPTH), combinational from count only (not from decode_ready);
//     full queue refuses push even if a pop occurs that cycle.
//   - decode_* driven combinationally from head entry (first-word fall-through).
//     Write-to-read latency: pair pushed at edge N is visible on decode_* after edge N.
//   - decode_valid = (count != 0). When count==0 data outputs hold 0.
//   - Even-slot qualifier stored per entry: even_valid = ~fetch_pc[0]. A branch target
//     at odd address yields decode_even_valid=0; decode issues the odd slot only.
//   - Pointers wrap modulo DEPTH. count: +1 push only, -1 pop only, unchanged on both.
//   - Simultaneous push and pop with 0<count<DEPTH: both occur, count unchanged, FIFO
//     order preserved.
//   - Push while empty and decode_ready=1: no bypass; pair appears next cycle.
//   - flush: at the edge, rd_ptr=wr_ptr=0, count=0; any same-cycle push and pop are
//     discarded. decode_valid=0 and fetch_ready=1 in the following cycle.
//   - reset has priority over flush; flush has priority over push/pop.
//   - Reset or flush mid-stream leaves no stale entry visible; storage contents need
//     not be cleared (outputs gated by count).
//   - Stable-hold rule: while decode_valid=1 and decode_ready=0, all decode_* outputs
//     hold their values.
// TESTING
//   - Reset: hold reset 2 cycles -> count=0, decode_valid=0, fetch_ready=1, outputs 0.
//   - Fill: push pc=0,2,4,6 with decode_ready=0 -> count=4, fetch_ready=0; 5th push
//     (pc=8) ignored; then drain with decode_ready=1 -> pcs 0,2,4,6 in order, then valid=0.
//   - Streaming: continuous push pc=0,2,4.. with decode_ready=1 -> count steady at 1,
//     decode_pc lags fetch_pc by one cycle, no drops or duplicates over 20 pairs.
//   - Odd target: push pc=0x15 (even=0xAAAA0000, odd=0xBBBB0000) -> decode_pc=0x15,
//     decode_even_valid=0, decode_instr_odd=0xBBBB0000.
//   - Flush: queue holds 3 pairs, assert flush with fetch_valid=1 pc=0x40 -> next cycle
//     count=0, decode_valid=0; pc=0x40 not present; subsequent push pc=0x42 reads out first.
//   - Wrap: 3 full fill/drain rounds of DEPTH pairs -> all pcs emerge in order across wrap.

Source files
------------

// File: rtl/instr_pair_buffer.sv
// Decoupling queue between instruction fetch and dual-issue decode: holds aligned
// even/odd instruction pairs with their PC and presents the head first-word fall-through.
module instr_pair_buffer #(
  parameter int DEPTH   = 4,
  parameter int INSTR_W = 32,
  parameter int PC_W    = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       fetch_valid,
  input  logic [PC_W-1:0]            fetch_pc,
  input  logic [INSTR_W-1:0]         fetch_instr_even,
  input  logic [INSTR_W-1:0]         fetch_instr_odd,
  output logic                       fetch_ready,
  input  logic                       flush,
  input  logic                       decode_ready,
  output logic                       decode_valid,
  output logic [PC_W-1:0]            decode_pc,
  output logic                       decode_even_valid,
  output logic [INSTR_W-1:0]         decode_instr_even,
  output logic [INSTR_W-1:0]         decode_instr_odd,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PC_W-1:0]    pc_mem   [DEPTH];
  logic [INSTR_W-1:0] even_mem [DEPTH];
  logic [INSTR_W-1:0] odd_mem  [DEPTH];
  logic               ev_mem   [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  // Ready depends only on occupancy, so a full queue refuses a push even when popping.
  assign fetch_ready  = (count != CNT_W'(DEPTH));
  assign decode_valid = (count != '0);
  assign push         = fetch_valid & fetch_ready;
  assign pop          = decode_valid & decode_ready;

  // Storage is never cleared; everything visible is gated by occupancy.
  always_ff @(posedge clock) begin
    if (push && !flush) begin
      pc_mem[wr_ptr]   <= fetch_pc;
      even_mem[wr_ptr] <= fetch_instr_even;
      odd_mem[wr_ptr]  <= fetch_instr_odd;
      ev_mem[wr_ptr]   <= ~fetch_pc[0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign decode_pc         = decode_valid ? pc_mem[rd_ptr]   : '0;
  assign decode_instr_even = decode_valid ? even_mem[rd_ptr] : '0;
  assign decode_instr_odd  = decode_valid ? odd_mem[rd_ptr]  : '0;
  assign decode_even_valid = decode_valid & ev_mem[rd_ptr];

endmodule

// File: tb/tb_instr_pair_buffer.sv
// Directed bench for instr_pair_buffer: reset, fill/full, streaming, odd branch target,
// flush, reset-over-flush and pointer wrap, each with hand-derived expectations.
module tb_instr_pair_buffer;

  localparam int DEPTH   = 4;
  localparam int INSTR_W = 32;
  localparam int PC_W    = 8;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               fetch_valid = 1'b0;
  logic [PC_W-1:0]    fetch_pc = '0;
  logic [INSTR_W-1:0] fetch_instr_even = '0;
  logic [INSTR_W-1:0] fetch_instr_odd = '0;
  logic               fetch_ready;
  logic               flush = 1'b0;
  logic               decode_ready = 1'b0;
  logic               decode_valid;
  logic [PC_W-1:0]    decode_pc;
  logic               decode_even_valid;
  logic [INSTR_W-1:0] decode_instr_even;
  logic [INSTR_W-1:0] decode_instr_odd;
  logic [2:0]         count;

  int ncmp = 0;
  int nerr = 0;

  instr_pair_buffer #(.DEPTH(DEPTH), .INSTR_W(INSTR_W), .PC_W(PC_W)) dut (
    .clock(clock), .reset(reset),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .fetch_instr_even(fetch_instr_even), .fetch_instr_odd(fetch_instr_odd),
    .fetch_ready(fetch_ready), .flush(flush), .decode_ready(decode_ready),
    .decode_valid(decode_valid), .decode_pc(decode_pc),
    .decode_even_valid(decode_even_valid), .decode_instr_even(decode_instr_even),
    .decode_instr_odd(decode_instr_odd), .count(count)
  );

  always #5 clock = ~clock;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_pair(input logic [PC_W-1:0] pc);
    fetch_pc         = pc;
    fetch_instr_even = 32'hE000_0000 | 32'(pc);
    fetch_instr_odd  = 32'hD000_0000 | 32'(pc);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    ncmp++; if (count !== 3'd0) begin $display("FAIL reset_count got=%0d exp=0", count); nerr++; end
    ncmp++; if (decode_valid !== 1'b0) begin $display("FAIL reset_valid got=%b exp=0", decode_valid); nerr++; end
    ncmp++; if (fetch_ready !== 1'b1) begin $display("FAIL reset_ready got=%b exp=1", fetch_ready); nerr++; end
    ncmp++; if (decode_pc !== 8'h00) begin $display("FAIL reset_pc got=%h exp=00", decode_pc); nerr++; end
    ncmp++; if (decode_even_valid !== 1'b0) begin $display("FAIL reset_ev got=%b exp=0", decode_even_valid); nerr++; end
    ncmp++; if ({decode_instr_even, decode_instr_odd} !== 64'h0) begin
      $display("FAIL reset_instr got=%h_%h exp=0", decode_instr_even, decode_instr_odd); nerr++; end
    reset = 1'b0;
  endtask

  task automatic test_fill();
    decode_ready = 1'b0;
    fetch_valid  = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      drive_pair(8'(2 * i));
      tick();
    end
    ncmp++; if (count !== 3'd4) begin $display("FAIL fill_count got=%0d exp=4", count); nerr++; end
    ncmp++; if (fetch_ready !== 1'b0) begin $display("FAIL fill_ready got=%b exp=0", fetch_ready); nerr++; end
    drive_pair(8'h08);
    tick();
    ncmp++; if (count !== 3'd4) begin $display("FAIL full_push_count got=%0d exp=4", count); nerr++; end
    ncmp++; if (decode_pc !== 8'h00) begin $display("FAIL hold_pc got=%h exp=00", decode_pc); nerr++; end
    // Full with push and pop together: only the pop takes effect.
    decode_ready = 1'b1;
    tick();
    fetch_valid = 1'b0;
    ncmp++; if (count !== 3'd3) begin $display("FAIL full_pushpop_count got=%0d exp=3", count); nerr++; end
    for (int i = 1; i < DEPTH; i++) begin
      ncmp++; if (decode_valid !== 1'b1 || decode_pc !== 8'(2 * i)) begin
        $display("FAIL drain_pc got=%h/v%b exp=%h", decode_pc, decode_valid, 8'(2 * i)); nerr++; end
      ncmp++; if (decode_instr_even !== (32'hE000_0000 | 32'(2 * i)) || decode_even_valid !== 1'b1) begin
        $display("FAIL drain_even got=%h/ev%b exp=%h", decode_instr_even, decode_even_valid, 32'hE000_0000 | 32'(2 * i)); nerr++; end
      tick();
    end
    ncmp++; if (decode_valid !== 1'b0 || count !== 3'd0 || decode_pc !== 8'h00) begin
      $display("FAIL drain_empty got=v%b c%0d pc%h exp=v0 c0 pc00", decode_valid, count, decode_pc); nerr++; end
    decode_ready = 1'b0;
  endtask

  task automatic test_streaming();
    decode_ready = 1'b1;
    fetch_valid  = 1'b1;
    drive_pair(8'h00);
    ncmp++; if (decode_valid !== 1'b0) begin $display("FAIL no_bypass got=%b exp=0", decode_valid); nerr++; end
    tick();
    for (int k = 1; k < 20; k++) begin
      drive_pair(8'(2 * k));
      ncmp++; if (count !== 3'd1 || decode_pc !== 8'(2 * (k - 1)) || decode_instr_odd !== (32'hD000_0000 | 32'(2 * (k - 1)))) begin
        $display("FAIL stream got=c%0d pc%h odd%h exp=c1 pc%h", count, decode_pc, decode_instr_odd, 8'(2 * (k - 1))); nerr++; end
      tick();
    end
    fetch_valid = 1'b0;
    ncmp++; if (count !== 3'd1 || decode_pc !== 8'h26) begin
      $display("FAIL stream_last got=c%0d pc%h exp=c1 pc26", count, decode_pc); nerr++; end
    tick();
    ncmp++; if (count !== 3'd0) begin $display("FAIL stream_empty got=%0d exp=0", count); nerr++; end
    decode_ready = 1'b0;
  endtask

  task automatic test_odd_target();
    fetch_valid      = 1'b1;
    fetch_pc         = 8'h15;
    fetch_instr_even = 32'hAAAA_0000;
    fetch_instr_odd  = 32'hBBBB_0000;
    tick();
    fetch_valid = 1'b0;
    tick();
    ncmp++; if (decode_pc !== 8'h15 || decode_even_valid !== 1'b0) begin
      $display("FAIL odd_pc got=pc%h ev%b exp=pc15 ev0", decode_pc, decode_even_valid); nerr++; end
    ncmp++; if (decode_instr_odd !== 32'hBBBB_0000 || decode_instr_even !== 32'hAAAA_0000) begin
      $display("FAIL odd_instr got=%h_%h exp=aaaa0000_bbbb0000", decode_instr_even, decode_instr_odd); nerr++; end
    decode_ready = 1'b1;
    tick();
    decode_ready = 1'b0;
  endtask

  task automatic test_flush();
    fetch_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_pair(8'(8'h10 + 2 * i));
      tick();
    end
    ncmp++; if (count !== 3'd3 || decode_pc !== 8'h10) begin
      $display("FAIL preflush got=c%0d pc%h exp=c3 pc10", count, decode_pc); nerr++; end
    flush        = 1'b1;
    decode_ready = 1'b1;
    drive_pair(8'h40);
    tick();
    flush        = 1'b0;
    fetch_valid  = 1'b0;
    decode_ready = 1'b0;
    ncmp++; if (count !== 3'd0 || decode_valid !== 1'b0 || fetch_ready !== 1'b1 || decode_pc !== 8'h00) begin
      $display("FAIL flush got=c%0d v%b r%b pc%h exp=c0 v0 r1 pc00", count, decode_valid, fetch_ready, decode_pc); nerr++; end
    fetch_valid = 1'b1;
    drive_pair(8'h42);
    tick();
    fetch_valid = 1'b0;
    ncmp++; if (count !== 3'd1 || decode_pc !== 8'h42) begin
      $display("FAIL postflush got=c%0d pc%h exp=c1 pc42", count, decode_pc); nerr++; end
    decode_ready = 1'b1;
    tick();
    decode_ready = 1'b0;
    // Reset wins over flush and a concurrent push.
    fetch_valid = 1'b1;
    drive_pair(8'h50); tick();
    drive_pair(8'h52); tick();
    reset = 1'b1; flush = 1'b1;
    drive_pair(8'h60); tick();
    reset = 1'b0; flush = 1'b0; fetch_valid = 1'b0;
    ncmp++; if (count !== 3'd0 || decode_valid !== 1'b0) begin
      $display("FAIL reset_flush got=c%0d v%b exp=c0 v0", count, decode_valid); nerr++; end
  endtask

  task automatic test_wrap();
    // Advance pointers off zero so every round straddles the wrap point.
    fetch_valid = 1'b1;
    drive_pair(8'h70); tick();
    fetch_valid = 1'b0; decode_ready = 1'b1; tick();
    decode_ready = 1'b0;
    for (int r = 0; r < 3; r++) begin
      fetch_valid = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        drive_pair(8'(8'h80 + r * 8 + 2 * i));
        tick();
      end
      fetch_valid = 1'b0;
      ncmp++; if (count !== 3'd4) begin $display("FAIL wrap_full got=%0d exp=4", count); nerr++; end
      decode_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        ncmp++; if (decode_pc !== 8'(8'h80 + r * 8 + 2 * i)) begin
          $display("FAIL wrap_pc got=%h exp=%h", decode_pc, 8'(8'h80 + r * 8 + 2 * i)); nerr++; end
        tick();
      end
      decode_ready = 1'b0;
      ncmp++; if (decode_valid !== 1'b0) begin $display("FAIL wrap_empty got=%b exp=0", decode_valid); nerr++; end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_streaming();
    test_odd_target();
    test_flush();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
